// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder
// Receive-side consumer for a Gray-coded bus that is asynchronous to clk.
// - Synchronises g_in through a SYNC_STAGES-deep flop chain.
// - Decodes the synchronised value to binary.
// - Classifies each change as a single up step, a single down step, or an
//   illegal multi-bit jump.
//
// Optional feature macro: GRAY_RX_ERR_CNT_EN
//   defined   : err_cnt is an 8-bit error counter that saturates at 255 and
//               clears only on rst.
//   undefined : no counter logic is built and err_cnt is tied to 0.
//
// Handshake: valid=1 means b_out is trusted (FSM in TRACK). step and err are
// single-cycle qualifiers on b_out. There is no ready; the consumer must
// sample each pulse in the cycle it is presented.
//
// Legal parameter ranges: WIDTH 2..16, SYNC_STAGES 2..4.
// The FSM state is kept in the internal signal 'state' (IDLE/TRACK/RESYNC)
// so that checkers can bind to it.
`timescale 1ns/1ps

module gray_rx_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] b_out,
  output logic             valid,
  output logic             step,
  output logic             up,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gs;
  logic [WIDTH-1:0] gp;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] diff;
  logic [4:0]       d;
  logic [WIDTH-1:0] delta;
  logic             d_zero;
  logic             d_one;
  logic             d_multi;

  logic [WIDTH-1:0] b_next;
  logic             valid_next;
  logic             step_next;
  logic             up_next;
  logic             err_next;

  // Input synchroniser chain. It keeps running whatever the value of en, so
  // that gs is already settled when tracking is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= g_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gs = sync_q[SYNC_STAGES-1];

  // Previous synchronised sample, used to measure how many bits changed.
  always_ff @(posedge clk) begin
    if (rst) begin
      gp <= '0;
    end else begin
      gp <= gs;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gs >> i);
    end
  end

  // Change classification.
  // - d: number of Gray bits that changed since the previous cycle.
  // - delta: signed step size relative to the current b_out.
  always_comb begin
    diff = gs ^ gp;
    d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d = d + {4'd0, diff[i]};
    end
    d_zero  = (d == 5'd0);
    d_one   = (d == 5'd1);
    d_multi = (d > 5'd1);
    delta   = bin - b_out;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output logic. All outputs are registered from here.
  always_comb begin
    state_next = state;
    b_next     = b_out;
    valid_next = valid;
    step_next  = 1'b0;
    err_next   = 1'b0;
    up_next    = up;

    if (!en) begin
      // Dropping en parks the block with b_out frozen and pulses suppressed.
      state_next = IDLE;
      valid_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          b_next     = bin;
          valid_next = 1'b1;
          state_next = TRACK;
        end

        TRACK: begin
          if (d_one) begin
            b_next    = bin;
            step_next = 1'b1;
            if (delta == DELTA_UP) begin
              up_next = 1'b1;
            end else if (delta == '1) begin
              up_next = 1'b0;
            end
          end else if (d_multi) begin
            b_next     = bin;
            err_next   = 1'b1;
            valid_next = 1'b0;
            state_next = RESYNC;
          end
        end

        RESYNC: begin
          // Follow the bus silently until it has been stable for one cycle.
          b_next = bin;
          if (d_zero) begin
            valid_next = 1'b1;
            state_next = TRACK;
          end
        end

        default: begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_out <= '0;
      valid <= 1'b0;
      step  <= 1'b0;
      up    <= 1'b0;
      err   <= 1'b0;
    end else begin
      b_out <= b_next;
      valid <= valid_next;
      step  <= step_next;
      up    <= up_next;
      err   <= err_next;
    end
  end

`ifdef GRAY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of illegal jumps. It advances in step with the err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (err_next && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Testbench for gray_rx_decoder (WIDTH=4, SYNC_STAGES=2).
// Expected step/err pulses are pushed by the driver together with the cycle
// on which they must appear. A negedge monitor pops and compares them.
// Directed checks cover reset, enable, err_cnt and reset during resync.
`timescale 1ns/1ps

module tb_gray_rx_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;
  localparam int W     = WIDTH + 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] b_out;
  logic             valid;
  logic             step;
  logic             up;
  logic             err;
  logic [7:0]       err_cnt;

  logic [W-1:0]     exp_q[$];
  int unsigned      exp_cyc_q[$];
  int unsigned      cyc;
  int               n_checks;
  int               n_fail;
  logic [W-1:0]     mon_e;
  int unsigned      mon_c;
  logic [3:0]       v;
  logic [7:0]       exp_cnt_first;
  logic [7:0]       exp_cnt_sat;

  gray_rx_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .g_in    (g_in),
    .b_out   (b_out),
    .valid   (valid),
    .step    (step),
    .up      (up),
    .err     (err),
    .err_cnt (err_cnt)
  );

  // Clock, cycle counter and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Checkers and driver tasks.
  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic pv, input logic ps, input logic pe,
                                      input logic pu, input logic [3:0] pb);
    return {pv, ps, pe, pu, pb};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new Gray value and record the pulse it must produce.
  // The pulse is due LAT edges after the current edge.
  task automatic drive_g(input logic [3:0] g, input logic [W-1:0] e);
    g_in = g;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + LAT);
  endtask

  // Monitor/scoreboard: compares every pulse the DUT presents.
  always @(negedge clk) begin
    n_checks++;
    if (step && err) begin
      n_fail++;
      $display("FAIL step_err_overlap: step=%0b err=%0b required not both (cycle %0d)", step, err, cyc);
    end
    if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
      n_checks++;
      n_fail++;
      $display("FAIL missed_pulse: nothing seen, expected %0h at cycle %0d (now %0d)",
               exp_q[0], exp_cyc_q[0], cyc);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (step || err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: step=%0b err=%0b b_out=%0h, none expected (cycle %0d)",
                 step, err, b_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check8("pulse_outputs{valid,step,err,up,b_out}", {valid, step, err, up, b_out}, mon_e);
        n_checks++;
        if (cyc != mon_c) begin
          n_fail++;
          $display("FAIL pulse_latency: got cycle %0d expected cycle %0d", cyc, mon_c);
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef GRAY_RX_ERR_CNT_EN
    exp_cnt_first = 8'd1;
    exp_cnt_sat   = 8'd255;
`else
    exp_cnt_first = 8'd0;
    exp_cnt_sat   = 8'd0;
`endif
    rst  = 1'b1;
    en   = 1'b0;
    g_in = 4'b0000;
    tick(3);
    @(negedge clk);
    check8("reset_b_out", 8'(b_out), 8'd0);
    check1("reset_valid", valid, 1'b0);
    check1("reset_step", step, 1'b0);
    check1("reset_up", up, 1'b0);
    check1("reset_err", err, 1'b0);
    check8("reset_err_cnt", err_cnt, 8'd0);

    // Enable with g_in=0.
    tick(1);
    rst = 1'b0;
    en  = 1'b1;
    tick(1);
    @(negedge clk);
    check1("enable_valid", valid, 1'b1);
    check8("enable_b_out", 8'(b_out), 8'd0);
    check1("enable_step", step, 1'b0);
    check1("enable_err", err, 1'b0);
    check8("enable_err_cnt", err_cnt, 8'd0);
    tick(1);

    // Walk up 1..15 then wrap to 0, one change every 4 cycles.
    for (int i = 1; i <= 16; i++) begin
      v = 4'(i);
      drive_g(v ^ (v >> 1), pk(1'b1, 1'b1, 1'b0, 1'b1, v));
      tick(4);
    end

    // Down steps: 0 -> 15 (0000->1000), then 15 -> 14 (1000->1001).
    drive_g(4'b1000, pk(1'b1, 1'b1, 1'b0, 1'b0, 4'd15));
    tick(4);
    drive_g(4'b1001, pk(1'b1, 1'b1, 1'b0, 1'b0, 4'd14));
    tick(4);

    // Drop en: valid falls, b_out holds. Re-enable on Gray 0010 (binary 3).
    en = 1'b0;
    tick(1);
    @(negedge clk);
    check1("disable_valid", valid, 1'b0);
    check8("disable_b_out_hold", 8'(b_out), 8'd14);
    g_in = 4'b0010;
    tick(4);
    en = 1'b1;
    tick(1);
    @(negedge clk);
    check1("reenable_valid", valid, 1'b1);
    check8("reenable_b_out", 8'(b_out), 8'd3);
    check1("reenable_step", step, 1'b0);
    tick(1);

    // Illegal jump 3 -> Gray 1100 (binary 8).
    drive_g(4'b1100, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'd8));
    tick(3);
    @(negedge clk);
    check8("jump_err_cnt", err_cnt, exp_cnt_first);
    check1("jump_valid_low", valid, 1'b0);
    check8("jump_b_out", 8'(b_out), 8'd8);
    @(negedge clk);
    check1("resync_valid", valid, 1'b1);
    check8("resync_b_out", 8'(b_out), 8'd8);
    check1("resync_no_step", step, 1'b0);
    check1("resync_no_err", err, 1'b0);
    tick(1);

    // 300 illegal jumps alternating between binary 0 and 8.
    for (int k = 1; k <= 300; k++) begin
      if (k % 2 == 1) drive_g(4'b0000, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
      else            drive_g(4'b1100, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'd8));
      tick(4);
    end
    @(negedge clk);
    check8("saturated_err_cnt", err_cnt, exp_cnt_sat);
    tick(1);

    // Reset while in RESYNC with g_in changing.
    drive_g(4'b0011, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'd2));
    tick(3);
    rst  = 1'b1;
    g_in = 4'b0101;
    tick(1);
    g_in = 4'b0110;
    @(negedge clk);
    check8("midrst_b_out", 8'(b_out), 8'd0);
    check1("midrst_valid", valid, 1'b0);
    check1("midrst_step", step, 1'b0);
    check1("midrst_up", up, 1'b0);
    check1("midrst_err", err, 1'b0);
    check8("midrst_err_cnt", err_cnt, 8'd0);
    tick(1);
    g_in = 4'b0000;
    rst  = 1'b0;
    tick(1);
    @(negedge clk);
    check1("post_rst_valid", valid, 1'b1);
    check8("post_rst_b_out", 8'(b_out), 8'd0);
    check1("post_rst_err", err, 1'b0);
    tick(6);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending pulses expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_rx_decoder.md
# gray_rx_decoder

Destination-side consumer for Gray-coded values produced by the binary-to-Gray stage. It synchronises an asynchronous Gray bus into `clk`, decodes it to binary, and classifies each change as a single up or down step or as an illegal multi-bit jump. It sits at the receive end of Gray-coded pointer and counter crossings and feeds binary position and step pulses to local control logic.

## Interface
- `WIDTH`, 4: Gray and binary bus width; legal values are 2 to 16.
- `SYNC_STAGES`, 2: flop stages in the input synchroniser; legal values are 2 to 4.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  enables tracking; the synchroniser runs regardless of `en`.
- `g_in`  in  WIDTH  Gray code, asynchronous to `clk`.
- `b_out`  out  WIDTH  registered binary decode of the synchronised Gray value.
- `valid`  out  1  `b_out` is trusted (state TRACK).
- `step`  out  1  one-cycle pulse on a legal single-bit Gray change.
- `up`  out  1  direction of the last `step`: 1 means +1 mod 2^WIDTH, 0 means −1; holds between steps.
- `err`  out  1  one-cycle pulse on a Gray change of more than one bit.
- `err_cnt`  out  8  saturating error count (see Configuration).

## Operation
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain on `g_in`; its final stage is `gs`.
- **Decode:** `bin[WIDTH-1] = gs[WIDTH-1]`; `bin[i] = bin[i+1] ^ gs[i]`.
- **Previous-sample register:** `gp`, loaded with `gs` every cycle.
- **Change detect:**
  - `d = popcount(gs ^ gp)`.
  - `delta = bin − b_out`, mod 2^WIDTH, WIDTH bits.
- **States:** IDLE, TRACK, RESYNC.
  - **IDLE:**
    - `valid`=0, `step`=0, `err`=0; `b_out` holds.
    - If `en`=1: `b_out` ← `bin`, `valid` ← 1, go to TRACK.
  - **TRACK:**
    - d=0: no change.
    - d=1: `b_out` ← `bin` and `step` ← 1.
      - `up` ← 1 if `delta`==1.
      - `up` ← 0 if `delta`==all-ones.
    - d>1: `b_out` ← `bin`, `err` ← 1, `valid` ← 0, `err_cnt` increments, go to RESYNC.
  - **RESYNC:**
    - `b_out` follows `bin` every cycle; no `step`, no further `err` pulses.
    - If d=0 for one cycle: `valid` ← 1, go to TRACK.
  - **Any state with `en`=0:** go to IDLE on the next edge; `valid` ← 0, pending pulses are suppressed, `b_out` holds.
- **Wrap-around:**
  - all-ones→0 is a legal up step (`delta`=1).
  - 0→all-ones is a legal down step.
  - For WIDTH=4: 15→0 is Gray 1000→0000.
- **`rst`:** state IDLE; all synchroniser flops, `gp`, `b_out`, `valid`, `step`, `up`, `err` and `err_cnt` are 0.
- **`rst` mid-operation:** the above applies on that edge, overriding `en` and any detected change.

## Timing
- **Latency:** with `g_in` stable before edge N, `gs` reflects it after edge N+SYNC_STAGES−1. `b_out`, `step` and `err` reflect it after edge N+SYNC_STAGES. With the default, that is 3 edges counting N.
- **Pulse width:** `step` and `err` are high for exactly one cycle per detected change. Back-to-back legal changes on consecutive cycles give consecutive pulses.
- **Enable:** `en` rising at edge M makes `valid`=1 after edge M, with `b_out` equal to the decode at that edge.
- **Ordering:** `step` and `err` are never high in the same cycle.
- **All outputs are registered**; there are no combinational paths from inputs.

## Configuration
- **`GRAY_RX_ERR_CNT_EN` defined:**
  - `err_cnt` is an 8-bit counter incremented on each `err` pulse.
  - It saturates at 255 and clears only on `rst`.
- **Not defined:**
  - No counter logic is built; `err_cnt` is tied to 0.
  - `err` behaviour is unchanged.

## Test plan
- Reset, then `en`=1 with `g_in`=0 → `valid`=1, `b_out`=0, and `step`, `err` and `err_cnt` all 0.
- `g_in` walked through the Gray codes for 0..15 then back to 0, one change every 4 cycles → 16 `step` pulses with `up`=1. `b_out` runs 1..15 then 0, each 3 edges after its `g_in` change.
- `g_in` Gray 0→15 (0000→1000), then 15→14 (1000→1001) → two `step` pulses with `up`=0; `b_out`=15, then 14.
- In TRACK with `b_out`=3 (Gray 0010), `g_in`→Gray 1100 (binary 8) → one `err` pulse, `valid`=0, `b_out`=8, `err_cnt`=1. After one stable cycle `valid`=1 again; no `step` is issued for the jump.
- 300 illegal jumps with the macro defined → `err_cnt`=255. Rebuild without the macro → `err_cnt`=0 with `err` still pulsing.
- `rst` asserted in RESYNC while `g_in` is changing → after that edge all outputs are 0 and the state is IDLE. Deasserting `rst` with `en`=1 reaches TRACK on the next edge.
